// File: rtl/mby_msh_pkg.sv
// Shared types and constants for the mesh-node memory datapath.
// MBY_MSH_MEM_DP_PAR_EN selects per-word parity storage.
package mby_msh_pkg;

    localparam int MBY_MSH_MEM_DATA_W = 64;
    localparam int MBY_MSH_MEM_TAG_W  = 8;

`ifdef MBY_MSH_MEM_DP_PAR_EN
    localparam int MBY_MSH_MEM_PAR_W = 1;
`else
    localparam int MBY_MSH_MEM_PAR_W = 0;
`endif

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mby_msh_mem_fsm_t;

    // Response word for the default widths; the datapath builds the same layout from its parameters.
    typedef struct packed {
        logic [MBY_MSH_MEM_DATA_W-1:0] data;
        logic [MBY_MSH_MEM_TAG_W-1:0]  tag;
        logic                          err;
    } mby_msh_mem_rsp_t;

endpackage

// File: rtl/mby_msh_mem_rsp_fifo.sv
// Valid/ready response FIFO; storage and pointers are registers, so a push is visible the next cycle.
// Full and empty are told apart by a wrap bit carried beside each pointer.
module mby_msh_mem_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
    logic             wr_wrap_q, rd_wrap_q;
    logic [W-1:0]     store_q [DEPTH];
    logic             empty, full, pop, wr_last, rd_last;

    assign empty     = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
    assign full      = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
    assign pop_valid = !empty;
    assign pop       = pop_ready && !empty;
    assign pop_data  = store_q[rd_idx_q];
    assign wr_last   = (wr_idx_q == IDX_W'(DEPTH - 1));
    assign rd_last   = (rd_idx_q == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_wrap_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
        end else begin
            if (push) begin
                store_q[wr_idx_q] <= push_data;
                wr_idx_q          <= wr_last ? '0 : wr_idx_q + 1'b1;
                wr_wrap_q         <= wr_wrap_q ^ wr_last;
            end
            if (pop) begin
                rd_idx_q  <= rd_last ? '0 : rd_idx_q + 1'b1;
                rd_wrap_q <= rd_wrap_q ^ rd_last;
            end
        end
    end

    // Upstream credits bound occupancy, so a push into a full FIFO is a design error.
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/mby_msh_mem_dp_pipe.sv
// Mesh-node memory datapath: self-initialising array, fixed-latency tagged reads, credit-guarded response FIFO.
// Optional parity per word under MBY_MSH_MEM_DP_PAR_EN.
module mby_msh_mem_dp_pipe
    import mby_msh_pkg::*;
#(
    parameter int DATA_W         = MBY_MSH_MEM_DATA_W,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int RD_LAT         = 2,
    parameter int TAG_W          = MBY_MSH_MEM_TAG_W,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic              mclk,
    input  logic              rst,
    output logic              init_done,
    output mby_msh_mem_fsm_t  dbg_state,
    // Every channel: a transfer happens on an edge where valid and ready are both high;
    // valid and payload are held by the source until then.
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    input  logic              par_err_inj
);

    localparam int WORD_W = DATA_W + MBY_MSH_MEM_PAR_W;
    localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } rsp_t;

    mby_msh_mem_fsm_t  state_q, state_d;
    logic              run;
    logic [ADDR_W-1:0] init_addr_q;
    logic [WORD_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wword, wr_word, rd_word;
    logic              wr_fire, rd_fire, rsp_pop, rd_err;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [RD_LAT-1:0] p_valid_q;
    rsp_t              p_rsp_q [RD_LAT];
    rsp_t              rd_rsp, fifo_out;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_addr_q <= init_addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        case (state_q)
            INIT:    if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
            RUN:     run = 1'b1;
            default: state_d = INIT;
        endcase
    end

    assign dbg_state = state_q;
    assign init_done = run;
    assign wr_ready  = run;
    assign wr_fire   = wr_valid && wr_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;
    // A response leaving this cycle hands its credit straight to a read arriving this cycle.
    assign rd_ready  = run && ((out_cnt_q < CNT_W'(RSP_FIFO_DEPTH)) || rsp_pop);
    assign rd_fire   = rd_valid && rd_ready;

`ifdef MBY_MSH_MEM_DP_PAR_EN
    assign wr_word = {(^wr_data) ^ par_err_inj, wr_data};
`else
    logic unused_par_err_inj;
    assign unused_par_err_inj = par_err_inj;
    assign wr_word = wr_data;
`endif

    always_comb begin
        mem_we    = wr_fire;
        mem_waddr = wr_addr;
        mem_wword = wr_word;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr_q;
            mem_wword = '0;
        end
    end

    always_ff @(posedge mclk) begin
        if (mem_we) mem[mem_waddr] <= mem_wword;
    end

    // Write-first: a same-cycle write to the read address is forwarded with its stored parity.
    assign rd_word = (wr_fire && (wr_addr == rd_addr)) ? wr_word : mem[rd_addr];

`ifdef MBY_MSH_MEM_DP_PAR_EN
    assign rd_err = (^rd_word[DATA_W-1:0]) ^ rd_word[DATA_W];
`else
    assign rd_err = 1'b0;
`endif

    assign rd_rsp = {rd_word[DATA_W-1:0], rd_tag, rd_err};

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            p_valid_q <= '0;
            out_cnt_q <= '0;
        end else begin
            p_valid_q[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) p_valid_q[i] <= p_valid_q[i-1];
            if (rd_fire && !rsp_pop)      out_cnt_q <= out_cnt_q + 1'b1;
            else if (!rd_fire && rsp_pop) out_cnt_q <= out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        p_rsp_q[0] <= rd_rsp;
        for (int i = 1; i < RD_LAT; i++) p_rsp_q[i] <= p_rsp_q[i-1];
    end

    mby_msh_mem_rsp_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (mclk),
        .rst       (rst),
        .push      (p_valid_q[RD_LAT-1]),
        .push_data (p_rsp_q[RD_LAT-1]),
        .pop_valid (rsp_valid),
        .pop_ready (rsp_ready),
        .pop_data  (fifo_out)
    );

    assign rsp_data = fifo_out.data;
    assign rsp_tag  = fifo_out.tag;
    assign rsp_err  = fifo_out.err;

endmodule

// File: tb/tb_mby_msh_mem_dp_pipe.sv
// Bench for mby_msh_mem_dp_pipe: word/queue model of the memory and response order, directed vectors.
// Parity vectors are included when MBY_MSH_MEM_DP_PAR_EN is defined.
module tb_mby_msh_mem_dp_pipe;
    import mby_msh_pkg::*;

    localparam int DW     = 64;
    localparam int TW     = 8;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int RD_LAT = 2;
    localparam int FD     = 4;
    localparam int EW     = DW + TW + 1;

    logic             mclk;
    logic             rst = 1'b1;
    logic             init_done;
    mby_msh_mem_fsm_t dbg_state;
    logic             wr_valid = 1'b0, wr_ready;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             rd_valid = 1'b0, rd_ready;
    logic [AW-1:0]    rd_addr = '0;
    logic [TW-1:0]    rd_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [DW-1:0]    rsp_data;
    logic [TW-1:0]    rsp_tag;
    logic             rsp_err;
    logic             par_err_inj = 1'b0;

    mby_msh_mem_dp_pipe dut (
        .mclk(mclk), .rst(rst), .init_done(init_done), .dbg_state(dbg_state),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .par_err_inj(par_err_inj)
    );

    // ---------------- clock / cycle counters ----------------
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    int cyc = 0;
    int since_rst = 0;
    always @(posedge mclk) cyc <= cyc + 1;
    always @(posedge mclk or posedge rst) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail = 0;
    int rsp_count = 0;
    logic [EW-1:0] exp_q[$];
    int            stamp_q[$];
    logic [DW-1:0] mdl_mem [DEPTH];
    logic          mdl_bad [DEPTH];
    int            popped_tags[$];
    logic [DW-1:0] popped_data[$];
    logic          popped_err[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: array of words, reads captured in accept order, responses compared while valid.
    initial begin : monitor
        logic          run_exp, pop;
        int            occ;
        logic [EW-1:0] e;
        forever begin
            @(negedge mclk);
            if (rst) begin
                exp_q.delete();
                stamp_q.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    mdl_mem[i] = '0;
                    mdl_bad[i] = 1'b0;
                end
            end else begin
                run_exp = (since_rst >= DEPTH);
                check("init_done", 64'(init_done), 64'(run_exp));
                check("wr_ready", 64'(wr_ready), 64'(run_exp));
                occ = exp_q.size();
                pop = rsp_valid && rsp_ready;
                if (occ == 0) begin
                    check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
                end else if (rsp_valid) begin
                    e = exp_q[0];
                    check("rsp_data", rsp_data, e[EW-1:TW+1]);
                    check("rsp_tag", 64'(rsp_tag), 64'(e[TW:1]));
                    check("rsp_err", 64'(rsp_err), 64'(e[0]));
                    check("rsp_latency", 64'(cyc >= stamp_q[0] + RD_LAT + 1), 64'd1);
                    if (pop) begin
                        popped_tags.push_back(int'(rsp_tag));
                        popped_data.push_back(rsp_data);
                        popped_err.push_back(rsp_err);
                        void'(exp_q.pop_front());
                        void'(stamp_q.pop_front());
                        rsp_count++;
                    end
                end
                check("rd_ready", 64'(rd_ready), 64'(run_exp && ((occ < FD) || pop)));
                if (wr_valid && wr_ready) begin
                    mdl_mem[wr_addr] = wr_data;
`ifdef MBY_MSH_MEM_DP_PAR_EN
                    mdl_bad[wr_addr] = par_err_inj;
`else
                    mdl_bad[wr_addr] = 1'b0;
`endif
                end
                if (rd_valid && rd_ready) begin
                    exp_q.push_back({mdl_mem[rd_addr], rd_tag, mdl_bad[rd_addr]});
                    stamp_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        int low_bad;
        rst = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0; par_err_inj = 1'b0;
        #2;
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_dbg_state", 64'(dbg_state), 64'(INIT));
        repeat (2) @(posedge mclk);
        #1 rst = 1'b0;
        low_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge mclk);
            if (init_done !== 1'b0) low_bad++;
        end
        check("init_low_window", 64'(low_bad), 64'd0);
        @(negedge mclk);
        check("init_done_rise", 64'(init_done), 64'd1);
        check("dbg_state_run", 64'(dbg_state), 64'(RUN));
        @(posedge mclk);
        #1;
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
        logic acc = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d; par_err_inj = inj;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge mclk);
            acc = wr_ready;
            @(posedge mclk);
            #1;
        end
        wr_valid = 1'b0; par_err_inj = 1'b0;
        check("wr_accept", 64'(acc), 64'd1);
    endtask

    task automatic do_rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
        logic acc = 1'b0;
        rd_valid = 1'b1; rd_addr = a; rd_tag = t;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge mclk);
            acc = rd_ready;
            @(posedge mclk);
            #1;
        end
        rd_valid = 1'b0;
        check("rd_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge mclk);
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge mclk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [AW-1:0] tbl_a [4];
    logic [DW-1:0] tbl_d [4];

    initial begin : main
        int   t0, first, n_acc, stale;
        logic acc;
        tbl_a[0] = 8'd0;   tbl_d[0] = 64'h0123_4567_89AB_CDEF;
        tbl_a[1] = 8'd255; tbl_d[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl_a[2] = 8'd1;   tbl_d[2] = 64'h8000_0000_0000_0001;
        tbl_a[3] = 8'd128; tbl_d[3] = 64'h0000_0000_DEAD_BEEF;

        @(posedge mclk);
        #1;
        do_reset();

        // Whole array reads back zero after initialisation.
        rsp_ready = 1'b1;
        rsp_count = 0;
        for (int a = 0; a < DEPTH; a++) do_rd(AW'(a), TW'(a));
        wait_drain(50);
        check("init_read_count", 64'(rsp_count), 64'd256);

        // Same-cycle write and read to addr 5: forwarded data, response at T+3.
        wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 64'hA5A5;
        rd_valid = 1'b1; rd_addr = 8'd5; rd_tag = 8'h11;
        @(negedge mclk);
        check("bypass_wr_ready", 64'(wr_ready), 64'd1);
        check("bypass_rd_ready", 64'(rd_ready), 64'd1);
        t0 = cyc;
        @(posedge mclk);
        #1 wr_valid = 1'b0; rd_valid = 1'b0;
        first = -1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            @(negedge mclk);
            if (rsp_valid) begin
                first = cyc;
                check("bypass_data", rsp_data, 64'hA5A5);
                check("bypass_tag", 64'(rsp_tag), 64'h11);
                check("bypass_err", 64'(rsp_err), 64'd0);
            end
        end
        check("bypass_first_cycle", 64'(first), 64'(t0 + 3));
        wait_drain(20);

        // Boundary addresses and distinct patterns.
        for (int i = 0; i < 4; i++) do_wr(tbl_a[i], tbl_d[i], 1'b0);
        popped_data.delete();
        for (int i = 0; i < 4; i++) do_rd(tbl_a[i], TW'(64 + i));
        wait_drain(50);
        check("tbl_count", 64'(popped_data.size()), 64'd4);
        for (int i = 0; i < 4 && i < popped_data.size(); i++)
            check("tbl_data", popped_data[i], tbl_d[i]);

        // Backpressure: only FD reads accepted while responses are blocked.
        popped_tags.delete();
        rsp_ready = 1'b0;
        rd_addr = 8'd5; rd_tag = 8'd1; rd_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge mclk);
            acc = rd_ready;
            @(posedge mclk);
            #1;
            if (acc) begin
                n_acc++;
                rd_tag = TW'(n_acc + 1);
            end
        end
        check("bp_accept_count", 64'(n_acc), 64'd4);
        @(negedge mclk);
        check("bp_rd_ready_low", 64'(rd_ready), 64'd0);
        check("bp_head_tag", 64'(rsp_tag), 64'd1);
        @(posedge mclk);
        #1 rsp_ready = 1'b1;
        @(negedge mclk);
        check("pop_credit_rd_ready", 64'(rd_ready), 64'd1);
        check("pop_head_tag", 64'(rsp_tag), 64'd1);
        @(posedge mclk);
        #1 rd_tag = 8'd6; rsp_ready = 1'b0;
        @(negedge mclk);
        check("full_after_swap_rd_ready", 64'(rd_ready), 64'd0);
        check("full_after_swap_head", 64'(rsp_tag), 64'd2);
        @(posedge mclk);
        #1 rsp_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge mclk);
            acc = rd_ready;
            @(posedge mclk);
            #1;
        end
        rd_valid = 1'b0;
        check("tag6_accept", 64'(acc), 64'd1);
        wait_drain(60);
        check("bp_pop_count", 64'(popped_tags.size()), 64'd6);
        for (int i = 0; i < 6 && i < popped_tags.size(); i++)
            check("bp_tag_order", 64'(popped_tags[i]), 64'(i + 1));

`ifdef MBY_MSH_MEM_DP_PAR_EN
        popped_err.delete();
        popped_data.delete();
        do_wr(8'd9, 64'h0F0F_0000_1234_5678, 1'b1);
        do_rd(8'd9, 8'h50);
        wait_drain(20);
        do_wr(8'd9, 64'h0F0F_0000_1234_5678, 1'b0);
        do_rd(8'd9, 8'h51);
        wait_drain(20);
        check("par_count", 64'(popped_err.size()), 64'd2);
        if (popped_err.size() == 2) begin
            check("par_inj_err", 64'(popped_err[0]), 64'd1);
            check("par_inj_data", popped_data[0], 64'h0F0F_0000_1234_5678);
            check("par_clean_err", 64'(popped_err[1]), 64'd0);
            check("par_clean_data", popped_data[1], 64'h0F0F_0000_1234_5678);
        end
`endif

        // Reset with three reads outstanding: nothing stale afterwards.
        rsp_ready = 1'b0;
        do_rd(8'd5, 8'h21);
        do_rd(8'd5, 8'h22);
        do_rd(8'd5, 8'h23);
        #2 check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
        do_reset();
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge mclk);
            if (rsp_valid) stale++;
        end
        check("no_stale_rsp", 64'(stale), 64'd0);
        @(posedge mclk);
        #1;
        popped_tags.delete();
        popped_data.delete();
        do_rd(8'd5, 8'h30);
        wait_drain(20);
        check("post_reset_count", 64'(popped_tags.size()), 64'd1);
        if (popped_tags.size() == 1) begin
            check("post_reset_tag", 64'(popped_tags[0]), 64'h30);
            check("post_reset_data", popped_data[0], 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mby_msh_mem_dp_pipe.md
Name: mby_msh_mem_dp_pipe

Overview:
Parametrised mesh-node memory datapath: single-port-write / single-port-read storage array with a fixed-latency read pipeline, tagged read responses and a credit-guarded response FIFO with valid/ready backpressure.
- Sits between the mesh node request decode and the mesh response return path.
- Self-initialises storage to zero after reset.
- Generalises the mesh memory datapath in width, depth, read latency and response buffering.

Parameters:
DATA_W, 64, data word width in bits
DEPTH, 256, number of words; power of two, at least 2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
RD_LAT, 2, read pipeline latency in cycles from read accept to FIFO write; at least 1
TAG_W, 8, read tag width
RSP_FIFO_DEPTH, 4, response FIFO entries; at least RD_LAT

Ports:
mclk  in  1  mesh clock
rst  in  1  reset; asynchronous, active-high
init_done  out  1  storage initialisation complete
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_valid  in  1  read request
rd_ready  out  1  read accepted when rd_valid and rd_ready are both high
rd_addr  in  ADDR_W  read address
rd_tag  in  TAG_W  tag returned with the response
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high
rsp_data  out  DATA_W  read data
rsp_tag  out  TAG_W  echoed tag
rsp_err  out  1  parity error on this response; tied 0 without the optional feature
par_err_inj  in  1  flip stored parity on the write; ignored without the optional feature

Behaviour:
- Reset values: init_done=0, wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0. Pipeline valids, FIFO pointers and credit counter are cleared.
- FSM states:
  - INIT: entered from reset. Address counter runs 0..DEPTH-1 and writes zero (parity 0) to one word per cycle. After the write to DEPTH-1, go to RUN.
  - RUN: init_done=1; stays in RUN until reset.
  - Total init time is DEPTH cycles after reset deassertion. init_done rises on the following edge.
- wr_ready = RUN. A write accepted at cycle T updates the array at the T edge.
- Write-first ordering: a read accepted at T returns data including a write accepted at T to the same address. Bypass compare is done at accept time.
- Reads:
  - Accepted at T; data, tag and error enter the FIFO at T+RD_LAT.
  - With an empty FIFO and rsp_ready=1, rsp_valid is high in cycle T+RD_LAT+1, i.e. the FIFO is registered-output. Minimum read-to-response latency is RD_LAT+1.
- Credits:
  - outstanding = reads in the pipeline + FIFO entries.
  - rd_ready = RUN and outstanding < RSP_FIFO_DEPTH.
  - Read accept and response pop in the same cycle leave the count unchanged.
  - The FIFO can never overflow; overflow is an assertion failure.
- Responses are in accept order. rsp_data/rsp_tag/rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
- FIFO full and empty are distinguished by pointer wrap bit. Pointers wrap modulo RSP_FIFO_DEPTH.
- Reset mid-operation: in-flight reads and FIFO contents are discarded without responses, and the FSM returns to INIT.
- Requests presented while ready=0 are not accepted. Requesters must hold them.
- Address out of range is not possible (power-of-two DEPTH).

Optional Feature:
MBY_MSH_MEM_DP_PAR_EN
- Defined:
  - Each word stores one extra even-parity bit over wr_data.
  - par_err_inj=1 on an accepted write stores the inverted parity bit.
  - On read, the recomputed parity is compared with the stored bit. A mismatch sets rsp_err=1 for that response only; data is returned unmodified.
  - Bypassed reads use the stored (possibly injected) parity.
- Undefined: no parity storage; rsp_err is tied to 0 and par_err_inj is unused.

Decomposition:
- mby_msh_pkg holds:
  - mby_msh_mem_fsm_t (INIT, RUN);
  - struct mby_msh_mem_rsp_t {data, tag, err}, parametrised by width localparams;
  - constant MBY_MSH_MEM_PAR_W, which is 1 or 0 depending on the macro.
- One sub-module: mby_msh_mem_rsp_fifo, a synchronous valid/ready FIFO with registered output, parametrised on width and depth.

Test Plan:
- Reset, then idle: init_done=0 for DEPTH=256 cycles and rises the cycle after. Reading all addresses then returns 0 with rsp_err=0.
- Write addr 5 = 0xA5A5 at T, read addr 5 tag 0x11 at T: response data 0xA5A5, tag 0x11, rsp_valid first high at T+RD_LAT+1 (T+3).
- rsp_ready=0 with back-to-back reads (tags 1..6):
  - exactly RSP_FIFO_DEPTH=4 accepted, then rd_ready=0;
  - after rsp_ready=1, tags 1,2,3,4 return in order;
  - one slot is freed per pop.
- Accept a read and pop a response in the same cycle with FIFO full: rd_ready stays 1 and occupancy stays at 4.
- Reset asserted with 3 reads outstanding: rsp_valid=0 immediately. FSM re-enters INIT, and no stale tags are seen after init_done.
- With MBY_MSH_MEM_DP_PAR_EN: write addr 9 with par_err_inj=1, then read it → rsp_err=1 with the correct data. Rewrite with par_err_inj=0, then read → rsp_err=0.
